// File: rtl/axis_replay_buf_pkg.sv
// axis_replay_buf_pkg: shared defaults and circular-pointer helper for the replay buffer.
package axis_replay_buf_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 9;
    localparam int unsigned BUF_SIZE_DEF   = 57;

    // Increment modulo n; works for any n >= 2, not only powers of two.
    function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned n);
        return (p + 1 == n) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/axis_replay_buf.sv
// axis_replay_buf: AXI-Stream buffer that retains the first BUF_SIZE beats of a packet for MAC replay.
//   clk, rst_n     : clock, asynchronous active-low reset
//   s_axis_*       : upstream beat input (data/valid/ready/last)
//   m_axis_*       : downstream beat output toward the MAC (data/valid/ready/last)
//   replay         : pulse, rewind read pointer to the packet's first retained beat
//   done           : pulse, commit packet, release beats already read
module axis_replay_buf
    import axis_replay_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned BUF_SIZE   = BUF_SIZE_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    input  logic                  replay,
    input  logic                  done
);

    localparam int unsigned PW = $clog2(BUF_SIZE);
    localparam int unsigned FW = $clog2(BUF_SIZE + 1);
    localparam logic [FW-1:0] FULL = FW'(BUF_SIZE);

    logic [DATA_WIDTH:0] mem [BUF_SIZE];
    logic [PW-1:0] start_q, start_d, rd_q, rd_d, wr_q, wr_d;
    // fill_q counts start..wr; rcnt_q counts start..rd, so unread = fill - rcnt
    // without the rd==wr full/empty ambiguity.
    logic [FW-1:0] fill_q, fill_d, rcnt_q, rcnt_d, rcnt_adv;
    logic          committed_q, committed_d, hold_q, hold_d;
    logic          wr_en, rd_en, rd_last, rewind, release_en;
    logic [DATA_WIDTH:0] rd_entry;

    assign rd_entry     = mem[rd_q];
    assign m_axis_data  = rd_entry[DATA_WIDTH:1];
    assign m_axis_last  = rd_entry[0];
    assign s_axis_ready = fill_q < FULL;
    assign m_axis_valid = (fill_q != rcnt_q) && !hold_q;

    always_comb begin
        wr_en       = s_axis_valid && s_axis_ready;
        rd_en       = m_axis_valid && m_axis_ready;
        rd_last     = rd_en && rd_entry[0];
        // done wins over replay; replay is ignored once committed
        rewind      = replay && !done && !committed_q;
        // committed reads free each beat as it goes; done frees everything read so far
        release_en  = done || (committed_q && rd_en);
        rd_d        = rewind ? start_q : rd_en ? PW'(wrap_inc(32'(rd_q), BUF_SIZE)) : rd_q;
        wr_d        = wr_en ? PW'(wrap_inc(32'(wr_q), BUF_SIZE)) : wr_q;
        rcnt_adv    = rcnt_q + FW'(rd_en && !rewind);
        start_d     = release_en ? rd_d : start_q;
        rcnt_d      = (release_en || rewind) ? '0 : rcnt_adv;
        fill_d      = fill_q + FW'(wr_en) - (release_en ? rcnt_adv : '0);
        hold_d      = (rewind || done) ? 1'b0 : (rd_last && !committed_q) ? 1'b1 : hold_q;
        // done after the last beat was already read starts the next packet immediately
        committed_d = done ? (!hold_q && !rd_last) : (committed_q && rd_last) ? 1'b0 : committed_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q     <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            fill_q      <= '0;
            rcnt_q      <= '0;
            committed_q <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            start_q     <= start_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            fill_q      <= fill_d;
            rcnt_q      <= rcnt_d;
            committed_q <= committed_d;
            hold_q      <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q] <= {s_axis_data, s_axis_last};
    end

endmodule

// File: tb/tb_axis_replay_buf.sv
// tb_axis_replay_buf: randomized scenarios checked cycle by cycle against a queue-level packet model.
module tb_axis_replay_buf;

    localparam int DW = 9;
    localparam int BS = 57;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_axis_data = '0;
    logic          s_axis_valid = 1'b0;
    logic          s_axis_ready;
    logic          s_axis_last = 1'b0;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready = 1'b0;
    logic          m_axis_last;
    logic          replay = 1'b0;
    logic          done = 1'b0;

    always #5 clk = ~clk;

    axis_replay_buf #(.DATA_WIDTH(DW), .BUF_SIZE(BS)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
        .s_axis_ready(s_axis_ready), .s_axis_last(s_axis_last),
        .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready), .m_axis_last(m_axis_last),
        .replay(replay), .done(done)
    );

    // Model: q_buf holds retained beats from the packet start; rd_off is the read position in it.
    logic [DW:0] q_buf[$];
    logic [DW:0] src[$];
    int          rd_off, n_rd;
    bit          m_com, m_hold;
    int          total = 0, passed = 0;

    function automatic bit exp_valid();
        return rd_off < q_buf.size() && !m_hold;
    endfunction

    function automatic logic [DW+2:0] expv();
        return {q_buf.size() < BS, exp_valid(), exp_valid() ? q_buf[rd_off] : (DW+1)'(0)};
    endfunction

    function automatic logic [DW+2:0] obs();
        return {s_axis_ready, m_axis_valid, m_axis_valid ? {m_axis_data, m_axis_last} : (DW+1)'(0)};
    endfunction

    task automatic model_reset();
        q_buf.delete();
        src.delete();
        rd_off = 0;
        n_rd   = 0;
        m_com  = 0;
        m_hold = 0;
    endtask

    task automatic load_pkt(input int n);
        for (int i = 0; i < n; i++) src.push_back({DW'($urandom), i == n - 1});
    endtask

    task automatic model_update(input bit sv, input logic [DW:0] b, input bit mr, input bit rp, input bit dn);
        bit wr, rd, lst, rew;
        wr  = sv && q_buf.size() < BS;
        rd  = exp_valid() && mr;
        lst = rd && q_buf[rd_off][0];
        rew = rp && !dn && !m_com;
        if (rew) begin
            rd_off = 0;
            m_hold = 0;
        end else begin
            if (rd) begin
                rd_off++;
                n_rd++;
            end
            if (dn) begin
                repeat (rd_off) void'(q_buf.pop_front());
                rd_off = 0;
                m_com  = !m_hold && !lst;
                m_hold = 0;
            end else if (m_com && rd) begin
                void'(q_buf.pop_front());
                rd_off = 0;
                if (lst) m_com = 0;
            end else if (lst) begin
                m_hold = 1;
            end
        end
        if (wr) begin
            q_buf.push_back(b);
            void'(src.pop_front());
        end
    endtask

    task automatic cycle(input bit sv_en, input bit mr, input bit rp, input bit dn);
        bit          sv;
        logic [DW:0] b;
        sv = sv_en && src.size() > 0;
        b  = sv ? src[0] : '0;
        s_axis_valid = sv;
        s_axis_data  = b[DW:1];
        s_axis_last  = b[0];
        m_axis_ready = mr;
        replay       = rp;
        done         = dn;
        @(posedge clk);
        model_update(sv, b, mr, rp, dn);
        #1;
        s_axis_valid = 0;
        m_axis_ready = 0;
        replay       = 0;
        done         = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (m_axis_valid === 1'b0 && s_axis_ready === 1'b1) passed++;
        else $display("FAIL reset_in: valid=%b ready=%b, want 0/1", m_axis_valid, s_axis_ready);
        rst_n = 1;
        model_reset();
        @(posedge clk);
        #1;
        total++;
        if (m_axis_valid === 1'b0 && s_axis_ready === 1'b1) passed++;
        else $display("FAIL reset_out: valid=%b ready=%b, want 0/1", m_axis_valid, s_axis_ready);
    endtask

    task automatic test_short_pkt();
        int holds = 0, pkts = 0;
        bit fin = 0, dn;
        n_rd = 0;
        load_pkt(10);
        load_pkt(10);
        for (int c = 0; c < 400 && !fin; c++) begin
            holds = m_hold ? holds + 1 : 0;
            dn = holds == 3;
            if (dn) pkts++;
            cycle($urandom_range(0, 3) != 0, 1'b1, 1'b0, dn);
            total++;
            if (obs() === expv()) passed++;
            else $display("FAIL short_pkt c%0d: got %h want %h", c, obs(), expv());
            fin = pkts == 2;
        end
        total++;
        if (fin && n_rd == 20) passed++;
        else $display("FAIL short_pkt_count: read %0d beats (fin=%0b), want 20", n_rd, fin);
    endtask

    task automatic test_replay();
        int reps = 0;
        bit fin = 0, rp, dn;
        n_rd = 0;
        load_pkt(20);
        for (int c = 0; c < 800 && !fin; c++) begin
            rp = (n_rd == 12 && reps == 0) || (m_hold && reps == 1);
            dn = m_hold && reps == 2;
            if (rp) reps++;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rp, dn);
            total++;
            if (obs() === expv()) passed++;
            else $display("FAIL replay c%0d: got %h want %h", c, obs(), expv());
            fin = dn;
        end
        total++;
        if (fin && n_rd == 52) passed++;
        else $display("FAIL replay_count: read %0d beats (fin=%0b), want 52", n_rd, fin);
    endtask

    task automatic test_overflow();
        bit sent = 0, fin = 0, dn;
        n_rd = 0;
        load_pkt(100);
        for (int c = 0; c < 1500 && !fin; c++) begin
            dn = n_rd == 57 && !sent;
            if (dn) begin
                total++;
                if (s_axis_ready === 1'b0) passed++;
                else $display("FAIL ovf_full: ready=%b, want 0", s_axis_ready);
                sent = 1;
            end
            cycle(1'b1, $urandom_range(0, 1) != 0, 1'b0, dn);
            if (dn) begin
                total++;
                if (s_axis_ready === 1'b1) passed++;
                else $display("FAIL ovf_release: ready=%b, want 1", s_axis_ready);
            end
            total++;
            if (obs() === expv()) passed++;
            else $display("FAIL overflow c%0d: got %h want %h", c, obs(), expv());
            fin = n_rd == 100;
        end
        total++;
        if (fin && m_axis_valid === 1'b0 && s_axis_ready === 1'b1) passed++;
        else $display("FAIL ovf_end: reads=%0d valid=%b ready=%b, want 100/0/1", n_rd, m_axis_valid, s_axis_ready);
    endtask

    task automatic test_done_replay();
        bit sent = 0, fin = 0, both;
        n_rd = 0;
        load_pkt(30);
        for (int c = 0; c < 600 && !fin; c++) begin
            both = n_rd == 8 && !sent;
            sent |= both;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, both, both);
            total++;
            if (obs() === expv()) passed++;
            else $display("FAIL done_replay c%0d: got %h want %h", c, obs(), expv());
            fin = n_rd == 30;
        end
        total++;
        if (fin && m_axis_valid === 1'b0 && s_axis_ready === 1'b1) passed++;
        else $display("FAIL done_replay_end: reads=%0d valid=%b ready=%b, want 30/0/1", n_rd, m_axis_valid, s_axis_ready);
    endtask

    task automatic test_stall();
        bit sent = 0, fin = 0, dn, sv_en;
        n_rd = 0;
        load_pkt(15);
        for (int c = 0; c < 600 && !fin; c++) begin
            dn = !sent && n_rd == 5;
            sv_en = sent ? $urandom_range(0, 2) != 0 : (15 - src.size()) < 5;
            cycle(sv_en, $urandom_range(0, 2) != 0, 1'b0, dn);
            sent |= dn;
            total++;
            if (obs() === expv()) passed++;
            else $display("FAIL stall c%0d: got %h want %h", c, obs(), expv());
            fin = n_rd == 15;
        end
        total++;
        if (fin && m_axis_valid === 1'b0 && s_axis_ready === 1'b1) passed++;
        else $display("FAIL stall_end: reads=%0d valid=%b ready=%b, want 15/0/1", n_rd, m_axis_valid, s_axis_ready);
    endtask

    task automatic test_mid_reset();
        bit fin = 0, dn;
        n_rd = 0;
        load_pkt(12);
        for (int c = 0; c < 6; c++) begin
            cycle(1'b1, $urandom_range(0, 1) != 0, 1'b0, 1'b0);
            total++;
            if (obs() === expv()) passed++;
            else $display("FAIL mid_reset_pre c%0d: got %h want %h", c, obs(), expv());
        end
        rst_n = 0;
        #1;
        total++;
        if (m_axis_valid === 1'b0 && s_axis_ready === 1'b1) passed++;
        else $display("FAIL mid_reset_now: valid=%b ready=%b, want 0/1", m_axis_valid, s_axis_ready);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        load_pkt(5);
        for (int c = 0; c < 200 && !fin; c++) begin
            dn = m_hold;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0, dn);
            total++;
            if (obs() === expv()) passed++;
            else $display("FAIL mid_reset_post c%0d: got %h want %h", c, obs(), expv());
            fin = dn;
        end
        total++;
        if (fin && n_rd == 5 && s_axis_ready === 1'b1) passed++;
        else $display("FAIL mid_reset_count: read %0d beats ready=%b, want 5/1", n_rd, s_axis_ready);
    endtask

    initial begin
        test_reset();
        test_short_pkt();
        test_replay();
        test_overflow();
        test_done_replay();
        test_stall();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axis_replay_buf.md
# axis_replay_buf

Replay-capable AXI-Stream buffer between the transmit-data source and the half-duplex MII transmit MAC. It keeps the first BUF_SIZE beats of the current packet so the MAC can restart the packet from its first beat after an early collision (`replay`). After the MAC commits the packet (`done`), the block releases that storage and acts as a plain FIFO until the packet's last beat has been read.

## Interface
- `DATA_WIDTH`, default 9: beat payload width. The MAC packs `{data[7:0], err}`.
- `BUF_SIZE`, default 57: number of retained beats (slot time minus preamble, plus 1). Any integer ≥ 2; need not be a power of two.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `s_axis_data` input DATA_WIDTH: upstream beat.
- `s_axis_valid` input 1: upstream beat valid.
- `s_axis_ready` output 1: buffer can accept a beat.
- `s_axis_last` input 1: final beat of the packet.
- `m_axis_data` output DATA_WIDTH: beat at the read pointer.
- `m_axis_valid` output 1: beat available.
- `m_axis_ready` input 1: consumer takes the beat.
- `m_axis_last` output 1: the beat at the read pointer is last.
- `replay` input 1: one-cycle pulse; restart the current packet from its first beat.
- `done` input 1: one-cycle pulse; commit the current packet and release its retained beats.

## Operation
- Storage: BUF_SIZE entries, each `{data, last}`. There are three pointers, `start`, `rd` and `wr`, each wrapping modulo BUF_SIZE. `fill` counts entries from `start` to `wr` (0..BUF_SIZE).
- Two flags: `committed` (done seen, last beat not yet read) and `hold` (last beat read while uncommitted).
- Write: occurs when `s_axis_valid && s_axis_ready`. Store the beat at `wr`, advance `wr`, increment `fill`. `s_axis_ready = fill < BUF_SIZE`. Writing is never blocked by packet boundaries.
- Read: occurs when `m_axis_valid && m_axis_ready`. `m_axis_valid = (rd != wr || fill == BUF_SIZE and rd == start before any read) && !hold`; in practice, valid is high when unread entries exist and `hold` is clear. `m_axis_data` and `m_axis_last` are driven combinationally from entry `rd`. Each read advances `rd`.
- Uncommitted read of the last beat: set `hold`. Output stays invalid until `replay` or `done` arrives.
- Committed operation: on every read, `start` follows `rd`, which frees the entry. On the last beat, clear `committed`; `start` then points to the next packet.
- `replay`, uncommitted: `rd <= start`, clear `hold`. Takes priority over a read in the same cycle.
- `replay`, committed: ignored.
- `done`: free all beats read so far, so `start <= rd` and `fill` drops by (rd − start). Clear `hold`. Set `committed` unless the last beat was already read (hold was set), in which case the next packet begins immediately.
- Simultaneous `done` and `replay`: `done` wins and `replay` is ignored.
- Simultaneous write and release/read in one cycle: `fill` is updated with the net value.

## Timing
- Reset values: pointers 0, `fill` 0, `committed` 0, `hold` 0. After reset, `s_axis_ready` is 1 and `m_axis_valid` is 0. Memory contents are not reset.
- Latency: a beat written in cycle N is presented on the m-side in cycle N+1.
- `replay` or `done` in cycle N: the m-side reflects the new `rd` or released state from cycle N+1.
- `s_axis_ready` deasserts when BUF_SIZE beats are retained and not released. It reasserts the cycle after `done` frees entries.
- `rst_n` asserted mid-packet: all state clears immediately and the partial packet is dropped.

## Structure
- Single module, roughly 150–250 lines. No package is needed; BUF_SIZE and DATA_WIDTH are parameters.
- Pointer width is `$clog2(BUF_SIZE)`; `fill` width is `$clog2(BUF_SIZE+1)`.
- The CRC `lfsr` is a separate block, not instantiated here.

## Test plan
- 10-beat packet, consumer always ready: beats come out in order with `last` on beat 10. Then valid is held low until `done`. A following packet then streams out.
- 20-beat packet with `replay` pulsed after 12 beats read: output restarts at beat 1 and the full 20 beats come out. A second `replay` after the last beat repeats the packet again.
- 100-beat packet, BUF_SIZE 57: `s_axis_ready` drops after 57 beats. `done` after 57 reads restores ready, and the remaining 43 beats stream as a FIFO.
- `done` and `replay` in the same cycle mid-packet: no rewind occurs and streaming continues.
- Upstream stalls (valid low) mid-packet, with `done` pulsed while empty (underflow drain): the read stream resumes and `start` is released correctly at `last`.
- `rst_n` pulled low mid-packet for 1 cycle: valid drops to 0 and ready is 1 immediately. A new 5-beat packet then passes intact.
